// File: rtl/display_controller.sv
// display_controller: converts a 32-bit word to eight active-low seven-segment
// digits with a sequential double-dabble (shift-and-add-3) engine.
// Optional build macro SIGNED_DISPLAY_EN: treat value as two's complement,
// show the sign on hex7 and the magnitude on hex6..hex0.
module display_controller #(
    parameter int BLANK_LEADING = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] value,
    output logic        busy,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7
);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

    state_t       state_reg, state_next;
    logic [31:0]  last_value_reg;
    logic [31:0]  shift_reg;
    logic [39:0]  bcd_reg;
    logic [5:0]   count_reg;
    logic         pending_reg;
    logic         busy_reg;
    logic [55:0]  result_reg;
    logic [55:0]  hex_reg;

    logic         capture, step, finish, load;
    logic [31:0]  magnitude;
    logic [39:0]  bcd_adj;
    logic [7:0]   digit_zero;
    logic [8:0]   upper_zero;
    logic [55:0]  digit_pattern;
    logic [55:0]  pattern;
    logic         overflow;

`ifdef SIGNED_DISPLAY_EN
    logic         negative_reg;
    assign magnitude = value[31] ? (~value + 32'd1) : value;
    // hex7 is reserved for the sign, so only seven magnitude digits fit
    assign overflow  = |bcd_reg[39:28];
`else
    assign magnitude = value;
    assign overflow  = |bcd_reg[39:32];
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // add-3 correction on every BCD nibble that is 5 or more, ahead of the shift
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // per-digit encoding; upper_zero[i] means digits i..7 are all zero
    assign upper_zero[8] = 1'b1;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_digit
            assign digit_zero[gi] = (bcd_reg[gi*4 +: 4] == 4'd0);
            assign upper_zero[gi] = digit_zero[gi] & upper_zero[gi+1];
            if (gi == 0) begin : g_units
                assign digit_pattern[6:0] = seg7(bcd_reg[3:0]);
            end else begin : g_upper
                assign digit_pattern[gi*7 +: 7] =
                    ((BLANK_LEADING != 0) && upper_zero[gi]) ? SEG_BLANK
                                                              : seg7(bcd_reg[gi*4 +: 4]);
            end
        end
    endgenerate

    // final display image: sign and overflow override the plain digits
    always_comb begin
        pattern = digit_pattern;
`ifdef SIGNED_DISPLAY_EN
        if (negative_reg) pattern[55:49] = SEG_DASH;
`endif
        if (overflow) pattern = {8{SEG_DASH}};
    end

    // state register
    always_ff @(posedge clock) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // next-state and datapath strobes; CONVERT spends 32 shift cycles plus one
    // cycle registering the encoded image so UPDATE is a plain register load
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pending_reg || (value != last_value_reg)) begin
                    capture    = 1'b1;
                    state_next = CONVERT;
                end
            end
            CONVERT: begin
                if (count_reg != 6'd32) begin
                    step = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                load       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // datapath: capture, shift-and-add-3, encode, display load
    always_ff @(posedge clock) begin
        if (reset) begin
            last_value_reg <= 32'd0;
            shift_reg      <= 32'd0;
            bcd_reg        <= 40'd0;
            count_reg      <= 6'd0;
            pending_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            result_reg     <= {8{SEG_BLANK}};
            hex_reg        <= {8{SEG_BLANK}};
`ifdef SIGNED_DISPLAY_EN
            negative_reg   <= 1'b0;
`endif
        end else begin
            if (capture) begin
                last_value_reg <= value;
                shift_reg      <= magnitude;
                bcd_reg        <= 40'd0;
                count_reg      <= 6'd0;
                pending_reg    <= 1'b0;
                busy_reg       <= 1'b1;
`ifdef SIGNED_DISPLAY_EN
                negative_reg   <= value[31];
`endif
            end
            if (step) begin
                {bcd_reg, shift_reg} <= {bcd_adj[38:0], shift_reg, 1'b0};
                count_reg            <= count_reg + 6'd1;
            end
            if (finish) result_reg <= pattern;
            if (load) begin
                hex_reg  <= result_reg;
                busy_reg <= 1'b0;
            end
        end
    end

    assign busy = busy_reg;
    assign hex0 = hex_reg[6:0];
    assign hex1 = hex_reg[13:7];
    assign hex2 = hex_reg[20:14];
    assign hex3 = hex_reg[27:21];
    assign hex4 = hex_reg[34:28];
    assign hex5 = hex_reg[41:35];
    assign hex6 = hex_reg[48:42];
    assign hex7 = hex_reg[55:49];

endmodule

// File: tb/tb_display_controller.sv
// tb_display_controller: directed checks of conversion results, latency,
// blanking, overflow, mid-conversion value changes and reset abort.
module tb_display_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        busy;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

    int vectors = 0;
    int errors  = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SD = 7'b0111111;
    localparam logic [6:0] BL = 7'b1111111;

    localparam logic [55:0] DISP_BLANK = {8{BL}};
    localparam logic [55:0] DISP_ZERO  = {{7{BL}}, S0};
    localparam logic [55:0] DISP_12345678 = {S1, S2, S3, S4, S5, S6, S7, S8};
    localparam logic [55:0] DISP_DASH  = {8{SD}};
    localparam logic [55:0] DISP_MAX   = {8{S9}};
    localparam logic [55:0] DISP_1000  = {{4{BL}}, S1, S0, S0, S0};
    localparam logic [55:0] DISP_5     = {{7{BL}}, S5};
    localparam logic [55:0] DISP_42    = {{6{BL}}, S4, S2};
    localparam logic [55:0] DISP_7     = {{7{BL}}, S7};

    display_controller #(.BLANK_LEADING(1)) dut (
        .clock (clock),
        .reset (reset),
        .value (value),
        .busy  (busy),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3),
        .hex4  (hex4),
        .hex5  (hex5),
        .hex6  (hex6),
        .hex7  (hex7)
    );

    always #5 clock = ~clock;

    function automatic logic [55:0] disp();
        return {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vector %0d %s: observed %h expected %h", vectors, tag, obs, exp);
    endtask

    // apply a new value and let the capturing edge happen
    task automatic start(input logic [31:0] v, input string tag);
        value = v;
        tick();
        check({tag, " busy@capture"}, {55'd0, busy}, 56'd1);
    endtask

    // count further busy cycles until done, then check cycle count and display
    task automatic wait_done(input int exp_cycles, input logic [55:0] exp, input string tag);
        int n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (!busy) break;
            n++;
        end
        check({tag, " busy_cycles"}, 56'(n), 56'(exp_cycles));
        check({tag, " display"}, disp(), exp);
    endtask

    initial begin
        reset = 1'b1;
        value = 32'd0;
        repeat (3) tick();
        check("reset busy", {55'd0, busy}, 56'd0);
        check("reset display", disp(), DISP_BLANK);
        reset = 1'b0;

        // pending start after reset with value 0
        start(32'd0, "zero");
        wait_done(33, DISP_ZERO, "zero");

        // value unchanged: no further conversion
        repeat (3) tick();
        check("idle no retrigger", {55'd0, busy}, 56'd0);

        // display holds during conversion
        start(32'd12345678, "12345678");
        repeat (20) tick();
        check("hold during convert", disp(), DISP_ZERO);
        wait_done(13, DISP_12345678, "12345678");

        start(32'd100000000, "overflow");
        wait_done(33, DISP_DASH, "overflow");

        start(32'd99999999, "max");
        wait_done(33, DISP_MAX, "max");

        start(32'd1000, "1000");
        wait_done(33, DISP_1000, "1000");

        start(32'hFFFFFFFF, "allones");
        wait_done(33, DISP_DASH, "allones");

        // change of value mid-conversion is deferred to the next IDLE cycle
        start(32'd5, "five");
        repeat (10) tick();
        value = 32'd42;
        wait_done(23, DISP_5, "five");
        tick();
        check("reassert busy", {55'd0, busy}, 56'd1);
        wait_done(33, DISP_42, "42");

        // reset aborts a conversion and clears the display
        start(32'd7, "seven");
        repeat (20) tick();
        reset = 1'b1;
        tick();
        check("abort busy", {55'd0, busy}, 56'd0);
        check("abort display", disp(), DISP_BLANK);
        reset = 1'b0;
        tick();
        check("restart busy", {55'd0, busy}, 56'd1);
        wait_done(33, DISP_7, "seven");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/display_controller.md
DISPLAY_CONTROLLER -- requirements
Module: display_controller

Interface
REQ-001 SHALL have parameter: BLANK_LEADING, default 1, 1 = leading-zero digits blanked, 0 = leading zeros shown as '0'.
REQ-002 SHALL have port: clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: value  input  32  word to display (register-file toDisplay, register 31).
REQ-005 SHALL have port: busy  output  1  high while a conversion is pending or in progress.
REQ-006 SHALL have ports: hex0..hex7  output  7 each  active-low segments, bit6=g..bit0=a; hex0 = least significant digit.

Function
REQ-007 SHALL use FSM states IDLE, CONVERT, UPDATE.
REQ-008 IDLE: on the edge where (value != last_value) or pending=1, SHALL capture value into last_value and a shift register, clear the BCD accumulator and pending, set busy=1, and go to CONVERT.
REQ-009 CONVERT: SHALL run exactly 32 shift-and-add-3 iterations, one per clock; any BCD nibble >= 5 gets +3 before each shift.
REQ-010 BCD accumulator SHALL be 40 bits (10 digits), so every 32-bit unsigned value converts exactly.
REQ-011 UPDATE: SHALL load hex0..hex7 from the result in one clock, clear busy, and return to IDLE.
REQ-012 Latency: hex outputs SHALL change on the 34th rising edge after the capturing edge; busy high for exactly 34 cycles.
REQ-013 Encoding (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, blank=1111111.
REQ-014 Overflow: if the result exceeds 99,999,999, all eight digits SHALL show '-'.
REQ-015 With BLANK_LEADING=1, zero digits above the most significant nonzero digit SHALL be blank; hex0 SHALL always show a digit.
REQ-016 Changes on value during CONVERT or UPDATE SHALL be ignored; the IDLE cycle after UPDATE SHALL re-compare against last_value and start a new conversion if different.
REQ-017 hex outputs SHALL hold their last displayed value throughout a conversion (no flicker).

Reset
REQ-018 On reset: state=IDLE, busy=0, hex0..hex7=1111111, last_value=0, BCD/shift registers=0, pending=1.
REQ-019 Reset SHALL take priority over all FSM activity, including mid-CONVERT; the partial result SHALL be discarded.
REQ-020 Because pending=1, the first IDLE cycle after reset SHALL start a conversion regardless of value.

Configuration
REQ-021 Macro SIGNED_DISPLAY_EN SHALL select signed mode.
REQ-022 When defined: value is two's complement; the magnitude SHALL be converted; a negative value SHALL show '-' on hex7 and magnitude on hex6..hex0.
REQ-023 When defined: overflow SHALL trigger when magnitude > 9,999,999; value 32'h80000000 SHALL report overflow.
REQ-024 When undefined: value is unsigned; no sign logic is synthesized; REQ-014 applies.

Verification
REQ-025 Reset, value=0 -> busy high 34 cycles; then hex0=1000000, hex1..hex7=1111111.
REQ-026 value=12345678 -> hex7..hex0 = 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000.
REQ-027 value=100000000 -> all hex = 0111111 (unsigned build).
REQ-028 value=5, then 42 applied at cycle 10 of CONVERT -> display '5' at edge 34; busy reasserts next cycle; '42' shown 34 edges later.
REQ-029 reset asserted at cycle 20 of CONVERT -> next edge busy=0, all hex blank; conversion restarts after reset release.
REQ-030 SIGNED_DISPLAY_EN, value=32'hFFFFFFFF -> hex7=0111111, hex0=1111001, hex1..hex6=1111111.
